// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg
// Shared types and constants for the pipeline control path.
//   ctrl_t      : per-instruction control bundle carried through EX/MEM/WB
//   CTRL_BUBBLE : all-zero bundle (valid = 0) used for stalls and flushes
//   FWD_*       : EX operand source selects
package ctrl_pipe_pkg;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jal;
        logic       jalr;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ctrl_hazard_unit.sv
// ctrl_hazard_unit
// Purely combinational stall / flush / forward decision logic.
// Build option: CTRL_PIPE_FWD_EN
//   defined   : MEM/WB forwarding, only load-use stalls
//   undefined : no forwarding, stall on any pending write to a source register
// Ports:
//   id_valid, id_rs1, id_rs2   : instruction in ID
//   ex_* / mem_* / wb_*        : fields of the registered stage bundles
//   ex_branch_taken            : branch outcome for the EX instruction
//   stall                      : hold PC and IF/ID, bubble into EX (already masked by flush)
//   flush                      : redirect in EX, squash younger work
//   forward_a, forward_b       : EX operand source selects
module ctrl_hazard_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_branch,
    input  logic                  ex_jal,
    input  logic                  ex_jalr,
    input  logic                  ex_branch_taken,
`ifdef CTRL_PIPE_FWD_EN
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
`else
    input  logic                  ex_reg_write,
`endif
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    // x0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic dep_hit(input logic                  valid,
                                     input logic                  writes,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs);
        return valid & writes & (rd != '0) & (rd == rs);
    endfunction

    logic stall_raw;

    always_comb begin
        stall_raw = 1'b0;
        forward_a = FWD_REG;
        forward_b = FWD_REG;
        flush     = ex_valid & ((ex_branch & ex_branch_taken) | ex_jal | ex_jalr);
`ifdef CTRL_PIPE_FWD_EN
        stall_raw = id_valid & (dep_hit(ex_valid, ex_mem_read, ex_rd, id_rs1) |
                                dep_hit(ex_valid, ex_mem_read, ex_rd, id_rs2));
        if (dep_hit(mem_valid, mem_reg_write, mem_rd, ex_rs1)) begin
            forward_a = FWD_MEM;
        end else if (dep_hit(wb_valid, wb_reg_write, wb_rd, ex_rs1)) begin
            forward_a = FWD_WB;
        end
        if (dep_hit(mem_valid, mem_reg_write, mem_rd, ex_rs2)) begin
            forward_b = FWD_MEM;
        end else if (dep_hit(wb_valid, wb_reg_write, wb_rd, ex_rs2)) begin
            forward_b = FWD_WB;
        end
`else
        // Without forwarding, the consumer waits until the producer leaves WB.
        stall_raw = id_valid & (dep_hit(ex_valid,  ex_reg_write,  ex_rd,  id_rs1) |
                                dep_hit(ex_valid,  ex_reg_write,  ex_rd,  id_rs2) |
                                dep_hit(mem_valid, mem_reg_write, mem_rd, id_rs1) |
                                dep_hit(mem_valid, mem_reg_write, mem_rd, id_rs2) |
                                dep_hit(wb_valid,  wb_reg_write,  wb_rd,  id_rs1) |
                                dep_hit(wb_valid,  wb_reg_write,  wb_rd,  id_rs2));
`endif
        // A redirect makes the ID instruction dead, so holding it is pointless.
        stall = stall_raw & ~flush;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe
// Carries the decoded control bundle through the EX/MEM/WB pipeline registers
// and drives stall, flush and forwarding selects for the datapath.
// Build option: CTRL_PIPE_FWD_EN (enables operand forwarding; see ctrl_hazard_unit)
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   id_valid, id_* controls, id_rs* : decoded instruction in ID
//   ex_branch_taken                 : branch outcome for the EX instruction
//   ex/mem/wb_ctrl, ex/mem/wb_rd    : registered stage bundles and destinations
//   pc_write_en, ifid_write_en      : low = hold PC and IF/ID
//   ifid_flush                      : squash IF/ID
//   forward_a, forward_b            : EX operand source selects
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_ADDR_W         = 5,
    parameter int NUM_STAGES_FLUSHED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_jal,
    input  logic                  id_jalr,
    input  logic [1:0]            id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output ctrl_t                 ex_ctrl,
    output ctrl_t                 mem_ctrl,
    output ctrl_t                 wb_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  ifid_flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    ctrl_t id_bundle;
    logic  stall;
    logic  flush;
    logic  ex_load;

`ifdef CTRL_PIPE_FWD_EN
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
`endif

    always_comb begin
        id_bundle = CTRL_BUBBLE;
        if (id_valid) begin
            id_bundle.valid      = 1'b1;
            id_bundle.branch     = id_branch;
            id_bundle.mem_read   = id_mem_read;
            id_bundle.mem_to_reg = id_mem_to_reg;
            id_bundle.alu_op     = id_alu_op;
            id_bundle.mem_write  = id_mem_write;
            id_bundle.alu_src    = id_alu_src;
            id_bundle.reg_write  = id_reg_write;
            id_bundle.jal        = id_jal;
            id_bundle.jalr       = id_jalr;
        end
    end

    // Stall or flush both inject a bubble; an invalid ID is a bubble too.
    assign ex_load = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl  <= CTRL_BUBBLE;
            mem_ctrl <= CTRL_BUBBLE;
            wb_ctrl  <= CTRL_BUBBLE;
            ex_rd    <= '0;
            mem_rd   <= '0;
            wb_rd    <= '0;
`ifdef CTRL_PIPE_FWD_EN
            ex_rs1   <= '0;
            ex_rs2   <= '0;
`endif
        end else begin
            wb_ctrl  <= mem_ctrl;
            wb_rd    <= mem_rd;
            mem_ctrl <= ex_ctrl;
            mem_rd   <= ex_rd;
            ex_ctrl  <= ex_load ? id_bundle : CTRL_BUBBLE;
            ex_rd    <= ex_load ? id_rd : '0;
`ifdef CTRL_PIPE_FWD_EN
            ex_rs1   <= ex_load ? id_rs1 : '0;
            ex_rs2   <= ex_load ? id_rs2 : '0;
`endif
        end
    end

    ctrl_hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_valid        (ex_ctrl.valid),
        .ex_branch       (ex_ctrl.branch),
        .ex_jal          (ex_ctrl.jal),
        .ex_jalr         (ex_ctrl.jalr),
        .ex_branch_taken (ex_branch_taken),
`ifdef CTRL_PIPE_FWD_EN
        .ex_mem_read     (ex_ctrl.mem_read),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
`else
        .ex_reg_write    (ex_ctrl.reg_write),
`endif
        .ex_rd           (ex_rd),
        .mem_valid       (mem_ctrl.valid),
        .mem_reg_write   (mem_ctrl.reg_write),
        .mem_rd          (mem_rd),
        .wb_valid        (wb_ctrl.valid),
        .wb_reg_write    (wb_ctrl.reg_write),
        .wb_rd           (wb_rd),
        .stall           (stall),
        .flush           (flush),
        .forward_a       (forward_a),
        .forward_b       (forward_b)
    );

    assign pc_write_en   = ~stall;
    assign ifid_write_en = ~stall;
    assign ifid_flush    = flush & (NUM_STAGES_FLUSHED > 0);

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam int K_NOP  = 0;
    localparam int K_ADD  = 1;
    localparam int K_LOAD = 2;
    localparam int K_BR   = 3;
    localparam int K_JAL  = 4;
    localparam int K_JALR = 5;
    localparam int K_JLD  = 6;

    // Hand-computed bundles, bit order:
    // valid branch mem_read mem_to_reg alu_op[1:0] mem_write alu_src reg_write jal jalr
    localparam logic [10:0] B_ADD  = 11'b1_0_0_0_10_0_0_1_0_0;
    localparam logic [10:0] B_LOAD = 11'b1_0_1_1_00_0_1_1_0_0;
    localparam logic [10:0] B_BR   = 11'b1_1_0_0_01_0_0_0_0_0;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_branch, id_mem_read, id_mem_to_reg, id_mem_write;
    logic id_alu_src, id_reg_write, id_jal, id_jalr;
    logic [1:0] id_alu_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic ex_branch_taken;
    ctrl_t ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic pc_write_en, ifid_write_en, ifid_flush;
    logic [1:0] forward_a, forward_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_ADDR_W(5), .NUM_STAGES_FLUSHED(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_jal(id_jal), .id_jalr(id_jalr), .id_alu_op(id_alu_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
        .ifid_flush(ifid_flush), .forward_a(forward_a), .forward_b(forward_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_id(input logic v, input int kind,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v;
        id_branch = 1'b0; id_mem_read = 1'b0; id_mem_to_reg = 1'b0; id_mem_write = 1'b0;
        id_alu_src = 1'b0; id_reg_write = 1'b0; id_jal = 1'b0; id_jalr = 1'b0;
        id_alu_op = 2'b00;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        case (kind)
            K_ADD:  begin id_alu_op = 2'b10; id_reg_write = 1'b1; end
            K_LOAD: begin id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_alu_src = 1'b1; id_reg_write = 1'b1; end
            K_BR:   begin id_branch = 1'b1; id_alu_op = 2'b01; end
            K_JAL:  begin id_jal = 1'b1; id_reg_write = 1'b1; end
            K_JALR: begin id_jalr = 1'b1; id_reg_write = 1'b1; id_alu_src = 1'b1; end
            K_JLD:  begin id_jal = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        set_id(1'b0, K_NOP, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ex_branch_taken = 1'b0;
        set_id(1'b0, K_NOP, 5'd0, 5'd0, 5'd0);
        #3;
        check_val("rst ex_ctrl", 32'(ex_ctrl), 32'd0);
        check_val("rst mem_ctrl", 32'(mem_ctrl), 32'd0);
        check_val("rst wb_ctrl", 32'(wb_ctrl), 32'd0);
        check_val("rst pc_we", 32'(pc_write_en), 32'd1);
        check_val("rst ifid_we", 32'(ifid_write_en), 32'd1);
        check_val("rst flush", 32'(ifid_flush), 32'd0);
        check_val("rst fwd", 32'({forward_a, forward_b}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Latency through EX, MEM, WB
        set_id(1'b1, K_ADD, 5'd2, 5'd3, 5'd1);
        #1 check_val("lat pc_we", 32'(pc_write_en), 32'd1);
        tick();
        check_val("lat ex_ctrl", 32'(ex_ctrl), 32'(B_ADD));
        check_val("lat ex_rd", 32'(ex_rd), 32'd1);
        set_id(1'b1, K_ADD, 5'd5, 5'd6, 5'd4);
        tick();
        check_val("lat mem_ctrl", 32'(mem_ctrl), 32'(B_ADD));
        check_val("lat mem_rd", 32'(mem_rd), 32'd1);
        check_val("lat ex_rd2", 32'(ex_rd), 32'd4);
        set_id(1'b1, K_ADD, 5'd8, 5'd9, 5'd7);
        tick();
        check_val("lat wb_ctrl", 32'(wb_ctrl), 32'(B_ADD));
        check_val("lat wb_rd", 32'(wb_rd), 32'd1);
        check_val("lat mem_rd2", 32'(mem_rd), 32'd4);

        // Asynchronous reset mid-run
        set_id(1'b0, K_NOP, 5'd0, 5'd0, 5'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("mrst valids", 32'({ex_ctrl.valid, mem_ctrl.valid, wb_ctrl.valid}), 32'd0);
        check_val("mrst rds", 32'({ex_rd, mem_rd, wb_rd}), 32'd0);
        check_val("mrst pc_we", 32'(pc_write_en), 32'd1);
        check_val("mrst fwd", 32'({forward_a, forward_b}), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Load-use
        set_id(1'b1, K_LOAD, 5'd1, 5'd0, 5'd5);
        tick();
        check_val("lu ex_load", 32'(ex_ctrl), 32'(B_LOAD));
        set_id(1'b1, K_ADD, 5'd5, 5'd2, 5'd6);
        #1;
        check_val("lu pc_we", 32'(pc_write_en), 32'd0);
        check_val("lu ifid_we", 32'(ifid_write_en), 32'd0);
        check_val("lu flush", 32'(ifid_flush), 32'd0);
        tick();
        check_val("lu bubble", 32'(ex_ctrl), 32'd0);
        check_val("lu mem_load", 32'(mem_ctrl), 32'(B_LOAD));
`ifdef CTRL_PIPE_FWD_EN
        #1 check_val("lu release", 32'(pc_write_en), 32'd1);
        tick();
        check_val("lu consumer", 32'(ex_ctrl), 32'(B_ADD));
        check_val("lu consumer rd", 32'(ex_rd), 32'd6);
        check_val("lu fwd_a wb", 32'(forward_a), 32'(2'b01));
        check_val("lu fwd_b", 32'(forward_b), 32'(2'b00));
`else
        #1 check_val("lu hold mem", 32'(pc_write_en), 32'd0);
        tick();
        check_val("lu bubble2", 32'(ex_ctrl), 32'd0);
        #1 check_val("lu hold wb", 32'(pc_write_en), 32'd0);
        tick();
        #1 check_val("lu release", 32'(pc_write_en), 32'd1);
        tick();
        check_val("lu consumer", 32'(ex_ctrl), 32'(B_ADD));
        check_val("lu fwd_a off", 32'(forward_a), 32'(2'b00));
`endif
        drain();

`ifdef CTRL_PIPE_FWD_EN
        // Forwarding priority and x0 exclusion
        set_id(1'b1, K_ADD, 5'd1, 5'd2, 5'd7); tick();
        set_id(1'b1, K_ADD, 5'd1, 5'd2, 5'd7); tick();
        set_id(1'b1, K_ADD, 5'd0, 5'd7, 5'd8); tick();
        #1;
        check_val("fwd mem wins", 32'(forward_b), 32'(2'b10));
        check_val("fwd a none", 32'(forward_a), 32'(2'b00));
        set_id(1'b1, K_ADD, 5'd1, 5'd2, 5'd0); tick();
        set_id(1'b1, K_ADD, 5'd1, 5'd2, 5'd0); tick();
        set_id(1'b1, K_ADD, 5'd0, 5'd0, 5'd9); tick();
        #1 check_val("fwd x0", 32'({forward_a, forward_b}), 32'd0);
        set_id(1'b1, K_ADD, 5'd1, 5'd2, 5'd7); tick();
        set_id(1'b0, K_NOP, 5'd0, 5'd0, 5'd0); tick();
        set_id(1'b1, K_ADD, 5'd7, 5'd3, 5'd10); tick();
        #1;
        check_val("fwd wb only", 32'(forward_a), 32'(2'b01));
        check_val("fwd wb b", 32'(forward_b), 32'(2'b00));
        drain();
`else
        // RAW stall without forwarding: held while producer is in EX, MEM, WB
        set_id(1'b1, K_ADD, 5'd1, 5'd2, 5'd3); tick();
        set_id(1'b1, K_ADD, 5'd3, 5'd4, 5'd11);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("raw stall %0d", i), 32'(pc_write_en), 32'd0);
            check_val($sformatf("raw fwd %0d", i), 32'(forward_a), 32'(2'b00));
            tick();
        end
        #1 check_val("raw release", 32'(pc_write_en), 32'd1);
        tick();
        check_val("raw consumer rd", 32'(ex_rd), 32'd11);
        check_val("raw consumer", 32'(ex_ctrl), 32'(B_ADD));
        drain();
        set_id(1'b1, K_ADD, 5'd1, 5'd2, 5'd0); tick();
        set_id(1'b1, K_ADD, 5'd0, 5'd0, 5'd12);
        #1 check_val("raw x0", 32'(pc_write_en), 32'd1);
        drain();
`endif

        // Taken / not-taken branch
        set_id(1'b1, K_BR, 5'd10, 5'd11, 5'd0); tick();
        check_val("br ex", 32'(ex_ctrl), 32'(B_BR));
        set_id(1'b1, K_ADD, 5'd13, 5'd14, 5'd12);
        ex_branch_taken = 1'b1;
        #1;
        check_val("br taken flush", 32'(ifid_flush), 32'd1);
        check_val("br taken pc_we", 32'(pc_write_en), 32'd1);
        check_val("br taken ifid_we", 32'(ifid_write_en), 32'd1);
        tick();
        check_val("br bubble", 32'(ex_ctrl), 32'd0);
        ex_branch_taken = 1'b0;
        set_id(1'b1, K_BR, 5'd10, 5'd11, 5'd0); tick();
        set_id(1'b1, K_ADD, 5'd13, 5'd14, 5'd12);
        #1 check_val("br not taken", 32'(ifid_flush), 32'd0);
        tick();
        check_val("br nt ex", 32'(ex_ctrl), 32'(B_ADD));
        ex_branch_taken = 1'b1;
        #1 check_val("br taken non-branch", 32'(ifid_flush), 32'd0);
        ex_branch_taken = 1'b0;
        drain();

        // Flush beats stall
        set_id(1'b1, K_JLD, 5'd0, 5'd0, 5'd1); tick();
        set_id(1'b1, K_ADD, 5'd1, 5'd2, 5'd13);
        #1;
        check_val("fs flush", 32'(ifid_flush), 32'd1);
        check_val("fs pc_we", 32'(pc_write_en), 32'd1);
        check_val("fs ifid_we", 32'(ifid_write_en), 32'd1);
        tick();
        check_val("fs bubble", 32'(ex_ctrl), 32'd0);
        drain();

        // jalr redirect
        set_id(1'b1, K_JALR, 5'd2, 5'd0, 5'd0); tick();
        set_id(1'b0, K_NOP, 5'd0, 5'd0, 5'd0);
        #1 check_val("jalr flush", 32'(ifid_flush), 32'd1);
        drain();

        // Invalid ID never stalls and enters EX as a bubble
        set_id(1'b1, K_LOAD, 5'd1, 5'd0, 5'd5); tick();
        set_id(1'b0, K_ADD, 5'd5, 5'd5, 5'd6);
        #1 check_val("inv no stall", 32'(pc_write_en), 32'd1);
        tick();
        check_val("inv bubble", 32'(ex_ctrl), 32'd0);
        check_val("inv rd", 32'(ex_rd), 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
